// File: rtl/mem_stage.sv
// mem_stage: RISC-V memory-access stage (load formatting, store lanes, req/ack handshake, stall, errors).
// Rev 1.0
`default_nettype none

module mem_stage #(
    parameter int XLEN           = 32,
    parameter int XREG_ADDRWIDTH = 5,
    parameter int TIMEOUT        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XLEN-1:0]           rd_in,
    input  logic                      rd_en_in,
    input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
    input  logic [4:0]                load_flag_in,
    input  logic [2:0]                store_flag_in,
    input  logic [XLEN-1:0]           store_data_in,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [XLEN-1:0]           dmem_wdata,
    input  logic [XLEN-1:0]           dmem_rdata,
    input  logic                      dmem_ack,
    output logic [XLEN-1:0]           rd_out,
    output logic                      rd_en_out,
    output logic [XREG_ADDRWIDTH-1:0] rd_addr_out,
    output logic                      stall_req,
    output logic                      misalign_err,
    output logic                      bus_err
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    WAIT     = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic is_load, is_store, mem_op, misalign, timeout_hit;
    logic ld_b, ld_h, ld_w, st_b, st_h, st_w;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // A load takes priority over a simultaneous store flag
    assign is_load  = |load_flag_in;
    assign is_store = ~is_load & (|store_flag_in);
    assign mem_op   = is_load | is_store;

    assign ld_b = is_load & (load_flag_in[0] | load_flag_in[3]);
    assign ld_h = is_load & ~ld_b & (load_flag_in[1] | load_flag_in[4]);
    assign ld_w = is_load & ~ld_b & ~ld_h;
    assign st_b = is_store & store_flag_in[0];
    assign st_h = is_store & ~store_flag_in[0] & store_flag_in[1];
    assign st_w = is_store & ~store_flag_in[0] & ~store_flag_in[1];

    assign misalign = ((ld_h | st_h) & rd_in[0]) |
                      ((ld_w | st_w) & (rd_in[1:0] != 2'b00));

    assign dmem_req    = rst & ((state == WAIT) | (mem_op & ~misalign));
    assign timeout_hit = dmem_req & ~dmem_ack & (cnt == CNT_LAST);
    assign stall_req   = dmem_req & ~dmem_ack & ~timeout_hit;
    assign bus_err     = timeout_hit;

    assign dmem_we      = dmem_req & is_store;
    assign dmem_addr    = rst ? {rd_in[XLEN-1:2], 2'b00} : '0;
    assign misalign_err = rst & mem_op & misalign;
    assign rd_addr_out  = rst ? rd_addr_in : '0;

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = '0;
        if (dmem_req) begin
            if (is_load) begin
                dmem_be = 4'b1111;
            end else if (st_b) begin
                dmem_be    = 4'b0001 << rd_in[1:0];
                dmem_wdata = {4{store_data_in[7:0]}};
            end else if (st_h) begin
                dmem_be    = rd_in[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{store_data_in[15:0]}};
            end else begin
                dmem_be    = 4'b1111;
                dmem_wdata = store_data_in;
            end
        end
    end

    assign ld_byte = dmem_rdata[{rd_in[1:0], 3'b000} +: 8];
    assign ld_half = rd_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_data = dmem_rdata;
        if (ld_b)
            ld_data = {{24{load_flag_in[0] & ld_byte[7]}}, ld_byte};
        else if (ld_h)
            ld_data = {{16{load_flag_in[1] & ld_half[15]}}, ld_half};
    end

    assign rd_out = !rst ? '0 : ((is_load & ~misalign) ? ld_data : rd_in);

    // Write-back is suppressed on misalignment, in stalled cycles and on timeout
    assign rd_en_out = rst & rd_en_in & ~misalign & ~(dmem_req & ~dmem_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (stall_req) begin
            state <= WAIT;
            cnt   <= cnt + CW'(1);
        end else begin
            state <= IDLE;
            cnt   <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a behavioural reference model.
// Rev 1.0
`default_nettype none

module tb_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_in;
    logic        rd_en_in;
    logic [4:0]  rd_addr_in;
    logic [4:0]  load_flag_in;
    logic [2:0]  store_flag_in;
    logic [31:0] store_data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] rd_out;
    logic        rd_en_out;
    logic [4:0]  rd_addr_out;
    logic        stall_req, misalign_err, bus_err;

    mem_stage #(.XLEN(32), .XREG_ADDRWIDTH(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rd_in(rd_in), .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
        .load_flag_in(load_flag_in), .store_flag_in(store_flag_in), .store_data_in(store_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .rd_out(rd_out), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
        .stall_req(stall_req), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  lf;
        logic [2:0]  sf;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        rden;
        logic [4:0]  raddr;
        logic [7:0]  lat;
    } txn_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        chk_rd;
        logic        rden;
        logic        mis;
        logic        berr;
        logic [7:0]  stalls;
        logic [4:0]  raddr;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    int   stall_cnt = 0;
    exp_t sb_q[$];
    exp_t cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: access size and lane arithmetic straight from the ISA rules
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          off, size;
        logic        ld, st;
        logic [31:0] lane, v, mask;
        e    = '0;
        off  = int'(t.addr & 32'd3);
        ld   = (t.lf != 5'd0);
        st   = !ld && (t.sf != 3'd0);
        size = 4;
        if (ld) begin
            if (t.lf[0] || t.lf[3]) size = 1;
            else if (t.lf[1] || t.lf[4]) size = 2;
        end else if (st) begin
            if (t.sf[0]) size = 1;
            else if (t.sf[1]) size = 2;
        end
        e.mis   = (ld || st) && (off % size != 0);
        e.req   = (ld || st) && !e.mis;
        e.we    = st;
        e.addr  = t.addr & ~32'd3;
        mask    = ((32'd1 << size) - 32'd1) << off;
        e.be    = ld ? 4'hF : mask[3:0];
        if (!st)            e.wdata = 32'd0;
        else if (size == 1) e.wdata = (t.sdata & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.wdata = (t.sdata & 32'hFFFF) * 32'h0001_0001;
        else                e.wdata = t.sdata;
        e.berr   = e.req && (int'(t.lat) >= TIMEOUT);
        e.stalls = !e.req ? 8'd0 : (e.berr ? 8'(TIMEOUT - 1) : t.lat);
        if (ld) begin
            lane = t.rdata >> (8 * off);
            if (size == 1) begin
                v = lane & 32'hFF;
                if (t.lf[0] && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = lane & 32'hFFFF;
                if (t.lf[1] && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = t.rdata;
            end
            e.rd = v;
        end else begin
            e.rd = t.addr;
        end
        e.chk_rd = !e.mis && !e.berr;
        e.rden   = t.rden && !e.mis && !e.berr;
        e.raddr  = t.raddr;
        return e;
    endfunction

    task automatic issue(input txn_t t);
        exp_t e;
        e = model(t);
        load_flag_in  = t.lf;
        store_flag_in = t.sf;
        rd_in         = t.addr;
        store_data_in = t.sdata;
        rd_en_in      = t.rden;
        rd_addr_in    = t.raddr;
        sb_q.push_back(e);
        for (int k = 0; k < TIMEOUT; k++) begin
            dmem_ack   = e.req ? (k == int'(t.lat)) : 1'($urandom_range(0, 1));
            dmem_rdata = (e.req && dmem_ack) ? t.rdata : $urandom;
            @(posedge clk); #1;
            if (!e.req || dmem_ack || k == TIMEOUT - 1) break;
        end
        dmem_ack = 1'b0;
    endtask

    function automatic txn_t mk(input logic [4:0] lf, input logic [2:0] sf, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata, input logic [7:0] lat);
        txn_t t;
        t.lf = lf; t.sf = sf; t.addr = addr; t.sdata = sdata; t.rdata = rdata;
        t.rden = 1'b1; t.raddr = 5'd9; t.lat = lat;
        return t;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: DUT output with no expected entry (t=%0t)", $time);
            end else begin
                cur = sb_q[0];
                if (dmem_req) begin
                    check("dmem_we", dmem_we, cur.we);
                    check("dmem_be", dmem_be, cur.be);
                    check("dmem_addr", dmem_addr, cur.addr);
                    if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
                end
                if (stall_req) begin
                    stall_cnt++;
                    check("rd_en_while_stalled", rd_en_out, 1'b0);
                    check("bus_err_while_stalled", bus_err, 1'b0);
                    if (stall_cnt > TIMEOUT) check("stall_bound", stall_cnt, TIMEOUT);
                end else begin
                    void'(sb_q.pop_front());
                    check("dmem_req", dmem_req, cur.req);
                    check("stall_cycles", stall_cnt, cur.stalls);
                    check("rd_en_out", rd_en_out, cur.rden);
                    check("misalign_err", misalign_err, cur.mis);
                    check("bus_err", bus_err, cur.berr);
                    check("rd_addr_out", rd_addr_out, cur.raddr);
                    if (cur.chk_rd) check("rd_out", rd_out, cur.rd);
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   sel;
        rst           = 1'b0;
        load_flag_in  = 5'b00100;
        store_flag_in = 3'b000;
        rd_in         = 32'h0000_0104;
        store_data_in = 32'hDEAD_BEEF;
        rd_en_in      = 1'b1;
        rd_addr_in    = 5'd7;
        dmem_ack      = 1'b0;
        dmem_rdata    = 32'h1234_5678;

        // Outputs forced low while reset is held, even with an active load presented
        #3;
        check("reset_ctrl", {dmem_req, dmem_we, dmem_be, stall_req, rd_en_out, misalign_err, bus_err}, 32'd0);
        check("reset_addr", dmem_addr, 32'd0);
        check("reset_rd_out", rd_out, 32'd0);
        check("reset_rd_addr", rd_addr_out, 32'd0);

        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("lw_pending_req", dmem_req, 1'b1);
        check("lw_pending_stall", stall_req, 1'b1);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("async_reset_req", dmem_req, 1'b0);
        check("async_reset_stall", stall_req, 1'b0);
        load_flag_in  = 5'd0;
        rd_in         = 32'd0;
        store_data_in = 32'd0;
        rd_en_in      = 1'b0;
        rd_addr_in    = 5'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("post_reset_ctrl", {dmem_req, dmem_we, dmem_be, stall_req, rd_en_out, misalign_err, bus_err}, 32'd0);
        check("post_reset_data", dmem_addr | dmem_wdata | rd_out, 32'd0);

        mon_en = 1'b1;
        issue(mk(5'b00001, 3'b000, 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 8'd0));
        issue(mk(5'b10000, 3'b000, 32'h0000_0102, 32'd0, 32'h8001_1234, 8'd3));
        issue(mk(5'b00000, 3'b001, 32'h0000_0201, 32'h1234_56AB, 32'd0, 8'd1));
        issue(mk(5'b00000, 3'b010, 32'h0000_0202, 32'h1234_56AB, 32'd0, 8'd0));
        issue(mk(5'b00000, 3'b100, 32'h0000_0102, 32'h1234_56AB, 32'd0, 8'd0));
        issue(mk(5'b00100, 3'b000, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, 8'(TIMEOUT + 4)));
        issue(mk(5'b00100, 3'b000, 32'h0000_0304, 32'd0, 32'hCAFE_F00D, 8'(TIMEOUT - 1)));

        for (int n = 0; n < 200; n++) begin
            sel     = $urandom_range(0, 9);
            t.lf    = 5'd0;
            t.sf    = 3'd0;
            if (sel < 5)       t.lf = 5'(1 << sel);
            else if (sel < 8)  t.sf = 3'(1 << (sel - 5));
            else if (sel == 9) begin
                t.lf = 5'(1 << $urandom_range(0, 4));
                t.sf = 3'(1 << $urandom_range(0, 2));
            end
            t.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
            t.sdata = $urandom;
            t.rdata = $urandom;
            t.rden  = 1'($urandom_range(0, 1));
            t.raddr = 5'($urandom);
            sel     = $urandom_range(0, 9);
            if (sel < 7)       t.lat = 8'($urandom_range(0, 4));
            else if (sel == 7) t.lat = 8'(TIMEOUT + 5);
            else if (sel == 8) t.lat = 8'(TIMEOUT - 1);
            else               t.lat = 8'd0;
            issue(t);
        end

        mon_en = 1'b0;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
